// File: rtl/dsa_pkg.sv
// dsa_pkg: shared types and constants for the bilinear accelerator job controller.
`default_nettype none

package dsa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      LAUNCH = 2'd2,
      RUN    = 2'd3
   } state_e;

   localparam int Q88_FRAC    = 8;
   localparam int MIN_DIM     = 2;
   localparam int DEF_TIMEOUT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/dsa_out_dim.sv
// dsa_out_dim: scales one Q8.8 image dimension and clamps the result to [1, dim_i].
`default_nettype none

module dsa_out_dim
   import dsa_pkg::*;
(
   input  logic [15:0] dim_i,
   input  logic [15:0] scale_i,
   output logic [15:0] dim_o
);

   logic [31:0] prod_w;
   logic [15:0] raw_w;

   always_comb begin
      prod_w = {16'd0, dim_i} * {16'd0, scale_i};
      raw_w  = 16'(prod_w >> Q88_FRAC);
      if (raw_w == 16'd0) begin
         dim_o = 16'd1;
      end else if (raw_w > dim_i) begin
         dim_o = dim_i;
      end else begin
         dim_o = raw_w;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dsa_job_ctrl.sv
// dsa_job_ctrl: validates and launches one interpolation job, supervises it with a
// timeout and cycle counter, and arbitrates the input BRAM between UI and core.
`default_nettype none

module dsa_job_ctrl
   import dsa_pkg::*;
#(
   parameter int AW      = 12,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk_sys,
   input  logic          rst_sys_n,
   input  logic          start_pulse,
   input  logic          mode_simd,
   input  logic [15:0]   cfg_in_w,
   input  logic [15:0]   cfg_in_h,
   input  logic [15:0]   cfg_scale_q88,
   output logic          core_start,
   output logic          core_sel,
   output logic [15:0]   core_in_w,
   output logic [15:0]   core_in_h,
   output logic [15:0]   core_out_w,
   output logic [15:0]   core_out_h,
   output logic [15:0]   core_scale,
   input  logic          core_done_seq,
   input  logic          core_done_simd,
   input  logic [AW-1:0] core_raddr,
   input  logic [AW-1:0] ui_raddr,
   input  logic          ui_we,
   input  logic [AW-1:0] ui_waddr,
   input  logic [7:0]    ui_wdata,
   output logic [AW-1:0] mem_raddr,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   output logic          status_busy,
   output logic          status_done,
   output logic          status_error,
   output logic [31:0]   perf_cycles
);

   state_e      state_q, state_d;
   logic        start_prev_q;
   logic        sel_q, sel_d;
   logic [15:0] in_w_q, in_w_d, in_h_q, in_h_d, scale_q, scale_d;
   logic [15:0] out_w_q, out_w_d, out_h_q, out_h_d;
   logic        done_q, done_d, error_q, error_d, busy_q, busy_d;
   logic [31:0] perf_q, perf_d;

   logic [15:0] out_w_w, out_h_w;
   logic [31:0] area_w;
   logic        start_rise_w, sel_done_w, invalid_w;

   dsa_out_dim u_out_w (.dim_i(in_w_q), .scale_i(scale_q), .dim_o(out_w_w));
   dsa_out_dim u_out_h (.dim_i(in_h_q), .scale_i(scale_q), .dim_o(out_h_w));

   assign start_rise_w = start_pulse & ~start_prev_q;
   assign sel_done_w   = sel_q ? core_done_simd : core_done_seq;
   assign area_w       = {16'd0, in_w_q} * {16'd0, in_h_q};
   assign invalid_w    = (in_w_q < 16'(MIN_DIM)) || (in_h_q < 16'(MIN_DIM)) ||
                         (scale_q == 16'd0) || (area_w > (32'd1 << AW));

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      in_w_d  = in_w_q;
      in_h_d  = in_h_q;
      scale_d = scale_q;
      out_w_d = out_w_q;
      out_h_d = out_h_q;
      done_d  = done_q;
      error_d = error_q;
      perf_d  = perf_q;
      case (state_q)
         IDLE: begin
            if (start_rise_w) begin
               sel_d   = mode_simd;
               in_w_d  = cfg_in_w;
               in_h_d  = cfg_in_h;
               scale_d = cfg_scale_q88;
               done_d  = 1'b0;
               error_d = 1'b0;
               perf_d  = 32'd0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            out_w_d = out_w_w;
            out_h_d = out_h_w;
            if (invalid_w) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            perf_d  = 32'd0;
            state_d = RUN;
         end
         RUN: begin
            perf_d = perf_q + 32'd1;
            // Completion takes priority over a timeout landing on the same cycle.
            if (sel_done_w) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (perf_d == 32'(TIMEOUT)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (ui_we && (state_q != IDLE)) begin
         error_d = 1'b1;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         sel_q        <= 1'b0;
         in_w_q       <= 16'd0;
         in_h_q       <= 16'd0;
         scale_q      <= 16'd0;
         out_w_q      <= 16'd0;
         out_h_q      <= 16'd0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
         perf_q       <= 32'd0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_pulse;
         sel_q        <= sel_d;
         in_w_q       <= in_w_d;
         in_h_q       <= in_h_d;
         scale_q      <= scale_d;
         out_w_q      <= out_w_d;
         out_h_q      <= out_h_d;
         done_q       <= done_d;
         error_q      <= error_d;
         busy_q       <= busy_d;
         perf_q       <= perf_d;
      end
   end

   // UI reads during a job intentionally see the core's address.
   assign mem_raddr = ((state_q == LAUNCH) || (state_q == RUN)) ? core_raddr : ui_raddr;
   assign mem_we    = ui_we && (state_q == IDLE);
   assign mem_waddr = ui_waddr;
   assign mem_wdata = ui_wdata;

   assign core_start   = (state_q == LAUNCH);
   assign core_sel     = sel_q;
   assign core_in_w    = in_w_q;
   assign core_in_h    = in_h_q;
   assign core_out_w   = out_w_q;
   assign core_out_h   = out_h_q;
   assign core_scale   = scale_q;
   assign status_busy  = busy_q;
   assign status_done  = done_q;
   assign status_error = error_q;
   assign perf_cycles  = perf_q;

endmodule

`default_nettype wire

// File: tb/tb_dsa_job_ctrl.sv
// tb_dsa_job_ctrl: table-driven job checks with a scoreboard, plus timeout, arbitration and reset sequences.
`default_nettype none

module tb_dsa_job_ctrl;

   localparam int AW = 12;

   logic          clk_sys = 1'b0;
   logic          rst_sys_n = 1'b0;
   logic          start_pulse = 1'b0, mode_simd = 1'b0;
   logic [15:0]   cfg_in_w = '0, cfg_in_h = '0, cfg_scale_q88 = '0;
   logic          core_done_seq = 1'b0, core_done_simd = 1'b0;
   logic [AW-1:0] core_raddr = '0, ui_raddr = '0, ui_waddr = '0;
   logic          ui_we = 1'b0;
   logic [7:0]    ui_wdata = '0;

   logic          core_start, core_sel, mem_we, status_busy, status_done, status_error;
   logic [15:0]   core_in_w, core_in_h, core_out_w, core_out_h, core_scale;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic [7:0]    mem_wdata;
   logic [31:0]   perf_cycles;

   logic          t_core_start, t_core_sel, t_mem_we, t_status_busy, t_status_done, t_status_error;
   logic [15:0]   t_core_in_w, t_core_in_h, t_core_out_w, t_core_out_h, t_core_scale;
   logic [AW-1:0] t_mem_raddr, t_mem_waddr;
   logic [7:0]    t_mem_wdata;
   logic [31:0]   t_perf_cycles;

   dsa_job_ctrl #(.AW(AW)) dut (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_pulse(start_pulse), .mode_simd(mode_simd),
      .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
      .core_start(core_start), .core_sel(core_sel), .core_in_w(core_in_w), .core_in_h(core_in_h),
      .core_out_w(core_out_w), .core_out_h(core_out_h), .core_scale(core_scale),
      .core_done_seq(core_done_seq), .core_done_simd(core_done_simd), .core_raddr(core_raddr),
      .ui_raddr(ui_raddr), .ui_we(ui_we), .ui_waddr(ui_waddr), .ui_wdata(ui_wdata),
      .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .status_busy(status_busy), .status_done(status_done), .status_error(status_error),
      .perf_cycles(perf_cycles)
   );

   dsa_job_ctrl #(.AW(AW), .TIMEOUT(50)) dut_to (
      .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_pulse(start_pulse), .mode_simd(mode_simd),
      .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
      .core_start(t_core_start), .core_sel(t_core_sel), .core_in_w(t_core_in_w), .core_in_h(t_core_in_h),
      .core_out_w(t_core_out_w), .core_out_h(t_core_out_h), .core_scale(t_core_scale),
      .core_done_seq(core_done_seq), .core_done_simd(core_done_simd), .core_raddr(core_raddr),
      .ui_raddr(ui_raddr), .ui_we(ui_we), .ui_waddr(ui_waddr), .ui_wdata(ui_wdata),
      .mem_raddr(t_mem_raddr), .mem_we(t_mem_we), .mem_waddr(t_mem_waddr), .mem_wdata(t_mem_wdata),
      .status_busy(t_status_busy), .status_done(t_status_done), .status_error(t_status_error),
      .perf_cycles(t_perf_cycles)
   );

   always #5 clk_sys = ~clk_sys;

   // k: cycles from the core_start cycle to the done pulse (0 = never); idle: cycles from start edge to IDLE.
   typedef struct {
      int w, h, scale, simd, k;
      int ok, done, err, ow, oh, perf, idle;
   } vec_t;

   vec_t vecs[12];
   vec_t tvecs[2];
   vec_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_job(input vec_t v, input int hold, input bit use_to);
      vec_t e;
      int   n, starts, idle_n, lpos;
      logic cs, bz;
      sb_q.push_back(v);
      @(negedge clk_sys);
      cfg_in_w      = 16'(v.w);
      cfg_in_h      = 16'(v.h);
      cfg_scale_q88 = 16'(v.scale);
      mode_simd     = (v.simd != 0);
      start_pulse   = 1'b1;
      n = 0; starts = 0; idle_n = -1; lpos = -1;
      while ((idle_n < 0 || n < hold + 4) && n < 400) begin
         @(negedge clk_sys);
         n++;
         core_done_seq  = 1'b0;
         core_done_simd = 1'b0;
         if (n >= hold) start_pulse = 1'b0;
         cs = use_to ? t_core_start : core_start;
         bz = use_to ? t_status_busy : status_busy;
         if (cs) begin
            starts++;
            lpos = n;
         end
         if (!bz) begin
            if (idle_n < 0) idle_n = n;
         end else if (lpos > 0 && v.k > 0 && n == lpos + v.k) begin
            if (v.simd != 0) core_done_simd = 1'b1;
            else core_done_seq = 1'b1;
         end else if (lpos > 0 && v.simd != 0 && n == lpos + 1) begin
            core_done_seq = 1'b1;
         end
      end
      core_done_seq  = 1'b0;
      core_done_simd = 1'b0;
      start_pulse    = 1'b0;
      e = sb_q.pop_front();
      chk("idle_latency", 32'(idle_n), 32'(e.idle));
      chk("launch_count", 32'(starts), 32'(e.ok));
      chk("status_done", 32'(use_to ? t_status_done : status_done), 32'(e.done));
      chk("status_error", 32'(use_to ? t_status_error : status_error), 32'(e.err));
      chk("perf_cycles", use_to ? t_perf_cycles : perf_cycles, 32'(e.perf));
      chk("core_sel", 32'(use_to ? t_core_sel : core_sel), 32'(e.simd));
      chk("core_in_w", 32'(use_to ? t_core_in_w : core_in_w), 32'(e.w));
      if (e.ok != 0) begin
         chk("core_out_w", 32'(use_to ? t_core_out_w : core_out_w), 32'(e.ow));
         chk("core_out_h", 32'(use_to ? t_core_out_h : core_out_h), 32'(e.oh));
      end
   endtask

   initial begin
      //            w    h    scale simd k    ok done err ow  oh    perf idle
      vecs[0]  = '{64,  64,   205, 0, 100,  1, 1, 0, 51,  51,  100, 103};
      vecs[1]  = '{64,  64,   256, 1,   6,  1, 1, 0, 64,  64,    6,   9};
      vecs[2]  = '{1,   64,   256, 0,   5,  0, 0, 1,  0,   0,    0,   2};
      vecs[3]  = '{80,  80,   256, 0,   5,  0, 0, 1,  0,   0,    0,   2};
      vecs[4]  = '{64,  64,   512, 0,   4,  1, 1, 0, 64,  64,    4,   7};
      vecs[5]  = '{64,  32,     1, 1,   3,  1, 1, 0,  1,   1,    3,   6};
      vecs[6]  = '{2,   2048, 128, 0,   7,  1, 1, 0,  1, 1024,   7,  10};
      vecs[7]  = '{2,   2049, 128, 0,   5,  0, 0, 1,  0,   0,    0,   2};
      vecs[8]  = '{64,  64,     0, 0,   5,  0, 0, 1,  0,   0,    0,   2};
      vecs[9]  = '{16,  2,    384, 1,   8,  1, 1, 0, 16,   2,    8,  11};
      vecs[10] = '{100, 40,   100, 0,  12,  1, 1, 0, 39,  15,   12,  15};
      vecs[11] = '{64,  1,    256, 0,   5,  0, 0, 1,  0,   0,    0,   2};
      tvecs[0] = '{64,  64,   256, 0,   0,  1, 0, 1, 64,  64,   50,  53};
      tvecs[1] = '{64,  64,   256, 0,  50,  1, 1, 0, 64,  64,   50,  53};

      repeat (3) @(negedge clk_sys);
      chk("rst_busy", 32'(status_busy), 32'd0);
      chk("rst_flags", {29'd0, core_start, status_done, status_error}, 32'd0);
      chk("rst_perf", perf_cycles, 32'd0);
      chk("rst_params", {core_in_w, core_out_h}, 32'd0);
      chk("rst_params2", {core_in_h, core_out_w}, 32'd0);
      chk("rst_scale_sel", {15'd0, core_sel, core_scale}, 32'd0);
      rst_sys_n = 1'b1;

      for (int i = 0; i < 12; i++) run_job(vecs[i], 1, 1'b0);

      // Arbitration across a SEQ job.
      @(negedge clk_sys);
      cfg_in_w = 16'd64; cfg_in_h = 16'd64; cfg_scale_q88 = 16'd256; mode_simd = 1'b0;
      ui_raddr = 12'd5; core_raddr = 12'd9;
      #1 chk("idle_raddr", 32'(mem_raddr), 32'd5);
      start_pulse = 1'b1;
      @(negedge clk_sys);
      start_pulse = 1'b0;
      #1 chk("check_raddr", 32'(mem_raddr), 32'd5);
      @(negedge clk_sys);
      #1 chk("launch_raddr", 32'(mem_raddr), 32'd9);
      @(negedge clk_sys);
      chk("run_raddr", 32'(mem_raddr), 32'd9);
      ui_we = 1'b1; ui_waddr = 12'd7; ui_wdata = 8'hAB;
      #1 chk("run_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk_sys);
      ui_we = 1'b0;
      chk("run_drop_err", 32'(status_error), 32'd1);
      chk("run_busy", 32'(status_busy), 32'd1);
      core_done_seq = 1'b1;
      @(negedge clk_sys);
      core_done_seq = 1'b0;
      chk("arb_done", 32'(status_done), 32'd1);
      chk("arb_idle", 32'(status_busy), 32'd0);
      ui_we = 1'b1;
      #1 chk("idle_mem_we", 32'(mem_we), 32'd1);
      chk("idle_waddr_wdata", {12'd0, mem_waddr, mem_wdata}, {12'd0, 12'd7, 8'hAB});
      @(negedge clk_sys);
      ui_we = 1'b0;

      // A start held for 8 cycles must launch exactly one job.
      run_job('{64, 64, 256, 0, 3, 1, 1, 0, 64, 64, 3, 6}, 8, 1'b0);

      // Reset in the middle of a SIMD job.
      @(negedge clk_sys);
      mode_simd = 1'b1; start_pulse = 1'b1;
      repeat (6) @(negedge clk_sys);
      start_pulse = 1'b0;
      chk("pre_rst_busy", 32'(status_busy), 32'd1);
      rst_sys_n = 1'b0;
      #1;
      chk("mid_rst_busy_sel", {30'd0, status_busy, core_sel}, 32'd0);
      chk("mid_rst_perf", perf_cycles, 32'd0);
      chk("mid_rst_params", {core_in_w, core_out_w}, 32'd0);
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      core_done_simd = 1'b1;
      @(negedge clk_sys);
      core_done_simd = 1'b0;
      @(negedge clk_sys);
      chk("post_rst_flags", {30'd0, status_done, status_error}, 32'd0);

      // Timeout behaviour on the TIMEOUT=50 instance.
      run_job(tvecs[0], 1, 1'b1);
      run_job(tvecs[1], 1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
